// File: rtl/bus_controller_if.sv
// Control bundle between the Mini SRC microsequencer (master) and the datapath/memory side (slave).
interface bus_controller_if #(
    parameter int unsigned OPW = 5
);
    logic [OPW-1:0] ir_opcode;
    logic           mem_ready;
    logic           stop;

    logic R0R15_out, HI_out, LO_out, ZHI_out, ZLO_out;
    logic PC_out, MDR_out, INPORT_out, C_out, BA_out;
    logic PC_in, IR_in, MAR_in, MDR_in, Y_in;
    logic Z_in, HI_in, LO_in, OUTPORT_in, R_in;
    logic Gra, Grb, Grc;
    logic IncPC, Read, Write;
    logic [OPW-1:0] alu_op;
    logic run;
    logic illegal;

    modport master (
        input  ir_opcode, mem_ready, stop,
        output R0R15_out, HI_out, LO_out, ZHI_out, ZLO_out,
               PC_out, MDR_out, INPORT_out, C_out, BA_out,
               PC_in, IR_in, MAR_in, MDR_in, Y_in,
               Z_in, HI_in, LO_in, OUTPORT_in, R_in,
               Gra, Grb, Grc, IncPC, Read, Write, alu_op, run, illegal
    );

    modport slave (
        output ir_opcode, mem_ready, stop,
        input  R0R15_out, HI_out, LO_out, ZHI_out, ZLO_out,
               PC_out, MDR_out, INPORT_out, C_out, BA_out,
               PC_in, IR_in, MAR_in, MDR_in, Y_in,
               Z_in, HI_in, LO_in, OUTPORT_in, R_in,
               Gra, Grb, Grc, IncPC, Read, Write, alu_op, run, illegal
    );
endinterface

// File: rtl/bus_controller.sv
// Mini SRC microsequencer: steps fetch/execute and decodes bus selects, load enables,
// memory strobes and ALU opcode from the registered state and the latched IR opcode.
module bus_controller #(
    parameter int unsigned     OPW    = 5,
    parameter logic [OPW-1:0]  ADD_OP = OPW'(5'b00011)
) (
    input  logic              clock,
    input  logic              clear,
    bus_controller_if.master  bus
);

    typedef enum logic [3:0] {
        S_F0   = 4'd0,
        S_F1   = 4'd1,
        S_F2   = 4'd2,
        S_F3   = 4'd3,
        S_E0   = 4'd4,
        S_E1   = 4'd5,
        S_E2   = 4'd6,
        S_E3   = 4'd7,
        S_E4   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_IMM, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST,
        C_MFHI, C_MFLO, C_IN, C_OUT, C_NOP, C_HALT, C_ILL
    } op_class_t;

    typedef struct packed {
        logic r0r15_out, hi_out, lo_out, zhi_out, zlo_out;
        logic pc_out, mdr_out, inport_out, c_out, ba_out;
        logic pc_in, ir_in, mar_in, mdr_in, y_in;
        logic z_in, hi_in, lo_in, outport_in, r_in;
        logic gra, grb, grc, inc_pc, read, write;
        logic [OPW-1:0] alu_op;
        logic run, illegal;
    } ctl_t;

    state_t    state;
    logic      armed;
    op_class_t op_class;
    ctl_t      ctl;

    function automatic op_class_t classify(input logic [OPW-1:0] op);
        op_class_t c;
        c = C_ILL;
        if (op >= OPW'(3) && op <= OPW'(11)) begin
            c = C_RTYPE;
        end else if (op >= OPW'(12) && op <= OPW'(14)) begin
            c = C_IMM;
        end else begin
            case (op)
                OPW'(0):  c = C_LD;
                OPW'(1):  c = C_LDI;
                OPW'(2):  c = C_ST;
                OPW'(15): c = C_MULDIV;
                OPW'(16): c = C_MULDIV;
                OPW'(17): c = C_UNARY;
                OPW'(18): c = C_UNARY;
                OPW'(22): c = C_IN;
                OPW'(23): c = C_OUT;
                OPW'(24): c = C_MFLO;
                OPW'(25): c = C_MFHI;
                OPW'(26): c = C_NOP;
                OPW'(27): c = C_HALT;
                default:  c = C_ILL;
            endcase
        end
        return c;
    endfunction

    // Final execute step of each instruction class; single-step classes end in E0.
    function automatic state_t last_step(input op_class_t c);
        state_t s;
        case (c)
            C_RTYPE, C_IMM, C_LDI: s = S_E2;
            C_UNARY:               s = S_E1;
            C_MULDIV:              s = S_E3;
            C_LD, C_ST:            s = S_E4;
            default:               s = S_E0;
        endcase
        return s;
    endfunction

    function automatic logic is_mem_wait(input state_t s, input op_class_t c);
        return (s == S_E3 && c == C_LD) || (s == S_E4 && c == C_ST);
    endfunction

    function automatic state_t next_state(input state_t s, input op_class_t c,
                                          input logic halt_req, input logic ready);
        state_t nxt;
        nxt = s;
        case (s)
            S_F0:   nxt = halt_req ? S_HALT : S_F1;
            S_F1:   nxt = S_F2;
            S_F2:   nxt = ready ? S_F3 : S_F2;
            S_F3:   nxt = S_E0;
            S_E0, S_E1, S_E2, S_E3, S_E4: begin
                if (c == C_HALT) begin
                    nxt = S_HALT;
                end else if (is_mem_wait(s, c) && !ready) begin
                    nxt = s;
                end else if (s == last_step(c)) begin
                    nxt = S_F0;
                end else begin
                    nxt = state_t'(4'(s) + 4'd1);
                end
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_F0;
        endcase
        return nxt;
    endfunction

    assign op_class = classify(bus.ir_opcode);

    // armed is low for the cycle after clear so F0 is presented with its strobes afterwards.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= S_F0;
            armed <= 1'b0;
        end else if (!armed) begin
            armed <= 1'b1;
        end else begin
            state <= next_state(state, op_class, bus.stop, bus.mem_ready);
        end
    end

    always_comb begin
        ctl     = '0;
        ctl.run = (state != S_HALT);
        if (armed) begin
            case (state)
                S_F0: begin
                    ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.z_in = 1'b1;
                end
                S_F1: begin ctl.zlo_out = 1'b1; ctl.pc_in = 1'b1; end
                S_F2: begin ctl.read = 1'b1; ctl.mdr_in = 1'b1; end
                S_F3: begin ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1; end
                S_E0: begin
                    case (op_class)
                        C_RTYPE, C_IMM: begin
                            ctl.grb = 1'b1; ctl.r0r15_out = 1'b1; ctl.y_in = 1'b1;
                        end
                        C_UNARY: begin
                            ctl.grb = 1'b1; ctl.r0r15_out = 1'b1; ctl.z_in = 1'b1;
                            ctl.alu_op = bus.ir_opcode;
                        end
                        C_MULDIV: begin
                            ctl.gra = 1'b1; ctl.r0r15_out = 1'b1; ctl.y_in = 1'b1;
                        end
                        C_LD, C_LDI, C_ST: begin
                            ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
                        end
                        C_MFHI: begin ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                        C_MFLO: begin ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                        C_IN: begin ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                        C_OUT: begin
                            ctl.gra = 1'b1; ctl.r0r15_out = 1'b1; ctl.outport_in = 1'b1;
                        end
                        C_ILL: ctl.illegal = 1'b1;
                        default: ;
                    endcase
                end
                S_E1: begin
                    case (op_class)
                        C_RTYPE: begin
                            ctl.grc = 1'b1; ctl.r0r15_out = 1'b1; ctl.z_in = 1'b1;
                            ctl.alu_op = bus.ir_opcode;
                        end
                        C_IMM: begin
                            ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = bus.ir_opcode;
                        end
                        C_UNARY: begin ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                        C_MULDIV: begin
                            ctl.grb = 1'b1; ctl.r0r15_out = 1'b1; ctl.z_in = 1'b1;
                            ctl.alu_op = bus.ir_opcode;
                        end
                        C_LD, C_LDI, C_ST: begin
                            ctl.c_out = 1'b1; ctl.z_in = 1'b1; ctl.alu_op = ADD_OP;
                        end
                        default: ;
                    endcase
                end
                S_E2: begin
                    case (op_class)
                        C_RTYPE, C_IMM, C_LDI: begin
                            ctl.zlo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                        end
                        C_MULDIV: begin ctl.zlo_out = 1'b1; ctl.lo_in = 1'b1; end
                        C_LD, C_ST: begin ctl.zlo_out = 1'b1; ctl.mar_in = 1'b1; end
                        default: ;
                    endcase
                end
                S_E3: begin
                    case (op_class)
                        C_MULDIV: begin ctl.zhi_out = 1'b1; ctl.hi_in = 1'b1; end
                        C_LD: begin ctl.read = 1'b1; ctl.mdr_in = 1'b1; end
                        // Read stays low so MDR takes the register value off the bus.
                        C_ST: begin
                            ctl.gra = 1'b1; ctl.r0r15_out = 1'b1; ctl.mdr_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_E4: begin
                    case (op_class)
                        C_LD: begin ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                        C_ST: ctl.write = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.R0R15_out  = ctl.r0r15_out;
    assign bus.HI_out     = ctl.hi_out;
    assign bus.LO_out     = ctl.lo_out;
    assign bus.ZHI_out    = ctl.zhi_out;
    assign bus.ZLO_out    = ctl.zlo_out;
    assign bus.PC_out     = ctl.pc_out;
    assign bus.MDR_out    = ctl.mdr_out;
    assign bus.INPORT_out = ctl.inport_out;
    assign bus.C_out      = ctl.c_out;
    assign bus.BA_out     = ctl.ba_out;
    assign bus.PC_in      = ctl.pc_in;
    assign bus.IR_in      = ctl.ir_in;
    assign bus.MAR_in     = ctl.mar_in;
    assign bus.MDR_in     = ctl.mdr_in;
    assign bus.Y_in       = ctl.y_in;
    assign bus.Z_in       = ctl.z_in;
    assign bus.HI_in      = ctl.hi_in;
    assign bus.LO_in      = ctl.lo_in;
    assign bus.OUTPORT_in = ctl.outport_in;
    assign bus.R_in       = ctl.r_in;
    assign bus.Gra        = ctl.gra;
    assign bus.Grb        = ctl.grb;
    assign bus.Grc        = ctl.grc;
    assign bus.IncPC      = ctl.inc_pc;
    assign bus.Read       = ctl.read;
    assign bus.Write      = ctl.write;
    assign bus.alu_op     = ctl.alu_op;
    assign bus.run        = ctl.run;
    assign bus.illegal    = ctl.illegal;

endmodule

// File: doc/bus_controller.md
Name: bus_controller

Overview:
Microsequencing control unit for the Mini SRC datapath. It steps fetch/execute cycles and drives the one-hot bus source selects, the register load enables, the memory strobes and the ALU opcode. It waits on a memory-ready handshake and stops on halt. It sits beside the bus, the register file (Gra/Grb/Grc select logic) and the memory interface.

Parameters:
OPW, 5, opcode width, taken from IR[31:27].
ADD_OP, 5'b00011, ALU code driven for address and immediate-add calculations.

Ports:
clock  in  1  system clock, rising edge.
clear  in  1  synchronous, active-low reset.
ir_opcode  in  5  IR[31:27] of the currently latched instruction.
mem_ready  in  1  memory has completed the current Read or Write.
stop  in  1  request halt, sampled only in state F0.
R0R15_out, HI_out, LO_out, ZHI_out, ZLO_out, PC_out, MDR_out, INPORT_out, C_out, BA_out  out  1 each  bus source selects.
PC_in, IR_in, MAR_in, MDR_in, Y_in, Z_in, HI_in, LO_in, OUTPORT_in, R_in  out  1 each  load enables.
Gra, Grb, Grc  out  1 each  register-field selects.
IncPC, Read, Write  out  1 each  PC increment and memory strobes.
alu_op  out  5  ALU operation code.
run  out  1  high while the processor is executing.
illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Moore FSM, registered state. All outputs are decoded from the state and the latched ir_opcode. Registered state plus a step counter is acceptable.
- On clear=0 at a clock edge: state=F0, run=1, every other output 0. This takes effect from any state, including during memory waits.
- At most one bus source select is high in any cycle. With no select high, the bus reads 0.
- Fetch sequence:
  - F0: PC_out, MAR_in, IncPC, Z_in. If stop=1, go to HALT instead of F1.
  - F1: ZLO_out, PC_in.
  - F2: Read, MDR_in. Hold F2 while mem_ready=0; go to F3 on the first cycle where mem_ready=1.
  - F3: MDR_out, IR_in.
  - Then E0.
- Execute states E0..E4 by opcode class. After the last step, go to F0.
- R-type (add 00011, sub, and, or, ror, rol, shr, shra, shl; 00100..01011): E0 Grb R0R15_out Y_in; E1 Grc R0R15_out Z_in alu_op=opcode; E2 ZLO_out Gra R_in.
- Immediate (addi 01100, andi 01101, ori 01110): E0 Grb R0R15_out Y_in; E1 C_out Z_in alu_op=opcode; E2 ZLO_out Gra R_in.
- neg 10001 / not 10010: E0 Grb R0R15_out Z_in alu_op=opcode; E1 ZLO_out Gra R_in.
- div 01111 / mul 10000: E0 Gra R0R15_out Y_in; E1 Grb R0R15_out Z_in alu_op=opcode; E2 ZLO_out LO_in; E3 ZHI_out HI_in.
- Address calculation for ld 00000, ldi 00001 and st 00010: E0 Grb BA_out Y_in; E1 C_out Z_in alu_op=ADD_OP.
- ldi continues: E2 ZLO_out Gra R_in.
- ld continues: E2 ZLO_out MAR_in; E3 Read MDR_in, held until mem_ready; E4 MDR_out Gra R_in.
- st continues: E2 ZLO_out MAR_in; E3 Gra R0R15_out MDR_in (Read=0, so MDR loads from the bus); E4 Write, held until mem_ready.
- mfhi 11001: E0 HI_out Gra R_in. mflo 11000: E0 LO_out Gra R_in.
- in 10110: E0 INPORT_out Gra R_in. out 10111: E0 Gra R0R15_out OUTPORT_in.
- nop 11010: straight to F0.
- halt 11011: go to HALT.
- Any other opcode (including branch and jump codes 10011..10101 and 11100..11111): pulse illegal for one cycle in E0, then go to F0.
- HALT: run=0, all other outputs 0. Only clear exits HALT.
- alu_op is 0 in every state that does not assert Z_in.
- mem_ready is ignored outside F2, E3 (ld) and E4 (st). A mem_ready already high on entry to a wait state completes that state in one cycle.

Test Plan:
- clear=0 mid-wait in F2 with mem_ready=0 -> next cycle state F0, run=1, Read=0, all selects 0.
- Fetch with mem_ready delayed 3 cycles -> Read/MDR_in high for 4 cycles, F0..F3 takes 7 cycles, IR_in high exactly once.
- Opcode 00011 (add) -> E1 shows Grc, R0R15_out, Z_in, alu_op=00011; E2 shows ZLO_out, Gra, R_in; next state F0.
- Opcode 01101 (andi) -> E1 shows C_out=1, R0R15_out=0, alu_op=01101.
- Opcode 00010 (st) with mem_ready=1 immediately -> E1 alu_op=00011; E3 shows MDR_in=1 with Read=0; E4 Write for one cycle; total 9 cycles F0..E4.
- Opcode 11011 (halt), then stop=1 sampled in F0 -> run=0 held for 20 cycles; clear pulse restarts F0 with run=1. Opcode 11111 -> illegal pulses once. Across the whole run, at most one bus select is high in any cycle.
